// File: rtl/cprv_pkg.sv
// Shared CPRV definitions for the data-memory responder.
// Holds the responder state enum, default geometry and helpers that derive the
// word-offset width (DMEM_LSB) and word-index width (DMEM_IDX_W).
package cprv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned DMEM_DATA_WIDTH = 64;
  localparam int unsigned DMEM_DEPTH      = 1024;

  // Byte-offset bits inside one data word.
  function automatic int unsigned dmem_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Word-index bits for a power-of-two depth.
  function automatic int unsigned dmem_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned DMEM_LSB   = dmem_lsb(DMEM_DATA_WIDTH);
  localparam int unsigned DMEM_IDX_W = dmem_idx_w(DMEM_DEPTH);

endpackage

// File: rtl/cprv_dmem_array.sv
// Single-port synchronous word RAM, kept separate so it can be replaced by an
// SRAM macro. Contents are not reset.
// Ports:
//   clk    rising-edge clock
//   en     access enable; nothing happens when low
//   we     1 = write wdata to idx, 0 = read idx into rdata
//   idx    word index
//   wdata  write data
//   rdata  read data, updated only by an enabled read and held otherwise
module cprv_dmem_array #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write-or-read port; rdata holds its value between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/cprv_dmem_responder.sv
// Data-memory responder: memory-side end of the mem stage's valid/ready
// request/response interface. One request at a time, one response after
// LATENCY cycles, response held under backpressure.
// Optional macro CPRV_DMEM_MISALIGN_ERR_EN adds err_dmem_o and rejects
// requests whose byte offset inside the word is non-zero.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_dmem_i        request valid        ready_dmem_o   request ready
//   addr_dmem_i         byte address         wdata_dmem_i   write data
//   w_en_dmem_i         1 = write, 0 = read
//   valid_mem_dmem_o    response valid       ready_mem_dmem_i response ready
//   rdata_dmem_o        read data (0 for writes)
//   err_dmem_o          misaligned request (only with the macro)
module cprv_dmem_responder
  import cprv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_dmem_i,
  output logic                  ready_dmem_o,
  input  logic [ADDR_WIDTH-1:0] addr_dmem_i,
  input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
  input  logic                  w_en_dmem_i,
  output logic                  valid_mem_dmem_o,
  input  logic                  ready_mem_dmem_i,
  output logic [DATA_WIDTH-1:0] rdata_dmem_o
`ifdef CPRV_DMEM_MISALIGN_ERR_EN
  ,
  output logic                  err_dmem_o
`endif
);

  localparam int unsigned LSB   = dmem_lsb(DATA_WIDTH);
  localparam int unsigned IDX_W = dmem_idx_w(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_rd_q, pend_rd_d;
  logic                  rd_sel_q, rd_sel_d;
  logic                  ready_d, valid_d;
  logic                  accept;
  logic                  misalign;
  logic                  rd_ok;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr;

  assign accept      = valid_dmem_i && (state_q == IDLE);
  assign idx         = addr_dmem_i[LSB +: IDX_W];
  assign unused_addr = ^addr_dmem_i;

`ifdef CPRV_DMEM_MISALIGN_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'(1) << LSB) - 64'(1));
  assign misalign = (addr_dmem_i & LSB_MASK) != '0;
`else
  assign misalign = 1'b0;
`endif

  // Read responses carry array data; writes and rejected requests carry zero.
  assign rd_ok = !w_en_dmem_i && !misalign;

  cprv_dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (accept && !misalign),
    .we   (w_en_dmem_i),
    .idx  (idx),
    .wdata(wdata_dmem_i),
    .rdata(ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

  // Next state: IDLE accepts, WAIT counts down, RESP holds until handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_rd_d = rd_ok;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (ready_mem_dmem_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track it.
  always_comb begin
    ready_d  = (state_d == IDLE);
    valid_d  = (state_d == RESP);
    rd_sel_d = (state_d == RESP) && pend_rd_d;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_dmem_o     <= 1'b1;
      valid_mem_dmem_o <= 1'b0;
      rd_sel_q         <= 1'b0;
    end else begin
      ready_dmem_o     <= ready_d;
      valid_mem_dmem_o <= valid_d;
      rd_sel_q         <= rd_sel_d;
    end
  end

  // The array output register is the response data register; it only changes
  // on an accept, so it is stable for the whole RESP phase. Gate to zero
  // outside read responses.
  assign rdata_dmem_o = rd_sel_q ? ram_rdata : '0;

`ifdef CPRV_DMEM_MISALIGN_ERR_EN
  logic pend_err_q;

  // Error flag captured at accept and presented with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_err_q <= 1'b0;
      err_dmem_o <= 1'b0;
    end else begin
      if (accept) begin
        pend_err_q <= misalign;
      end
      err_dmem_o <= (state_d == RESP) && (accept ? misalign : pend_err_q);
    end
  end
`endif

endmodule

// File: tb/tb_cprv_dmem_responder.sv
// Self-checking bench for cprv_dmem_responder: one instance with LATENCY=1 and
// one with LATENCY=4, checked against a word-array reference model.
// Honors CPRV_DMEM_MISALIGN_ERR_EN when defined.
module tb_cprv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i [2];
  logic        we_i    [2];
  logic        rmem_i  [2];
  logic [63:0] addr_i  [2];
  logic [63:0] wdata_i [2];
  logic        ready_o [2];
  logic        vmem_o  [2];
  logic [63:0] rdata_o [2];
`ifdef CPRV_DMEM_MISALIGN_ERR_EN
  logic        err_o   [2];
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] model [2][1024];
  bit          known [2][1024];

  always #5 clk = ~clk;

  cprv_dmem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_dmem_i    (valid_i[0]),
    .ready_dmem_o    (ready_o[0]),
    .addr_dmem_i     (addr_i[0]),
    .wdata_dmem_i    (wdata_i[0]),
    .w_en_dmem_i     (we_i[0]),
    .valid_mem_dmem_o(vmem_o[0]),
    .ready_mem_dmem_i(rmem_i[0]),
    .rdata_dmem_o    (rdata_o[0])
`ifdef CPRV_DMEM_MISALIGN_ERR_EN
    ,
    .err_dmem_o      (err_o[0])
`endif
  );

  cprv_dmem_responder #(.LATENCY(4)) u_dut_l4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_dmem_i    (valid_i[1]),
    .ready_dmem_o    (ready_o[1]),
    .addr_dmem_i     (addr_i[1]),
    .wdata_dmem_i    (wdata_i[1]),
    .w_en_dmem_i     (we_i[1]),
    .valid_mem_dmem_o(vmem_o[1]),
    .ready_mem_dmem_i(rmem_i[1]),
    .rdata_dmem_o    (rdata_o[1])
`ifdef CPRV_DMEM_MISALIGN_ERR_EN
    ,
    .err_dmem_o      (err_o[1])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full request/response. If nxt_valid, a read of nxt_addr is held
  // pending during backpressure and left asserted after the handshake.
  task automatic txn(input int d, input logic [63:0] addr, input logic [63:0] wd,
                     input logic we, input int bp,
                     input logic nxt_valid, input logic [63:0] nxt_addr);
    int          lat = (d == 0) ? 1 : 4;
    int          idx = int'((addr / 64'd8) % 64'd1024);
    bit          mis = 1'b0;
    bit          chk_rd;
    logic [63:0] exp_rd;
`ifdef CPRV_DMEM_MISALIGN_ERR_EN
    mis = (addr % 64'd8) != 64'd0;
`endif
    if (we || mis) begin
      exp_rd = 64'd0;
      chk_rd = 1'b1;
    end else begin
      exp_rd = model[d][idx];
      chk_rd = known[d][idx];
    end
    @(negedge clk);
    chk("ready_idle", 64'(ready_o[d]), 64'd1);
    chk("valid_idle", 64'(vmem_o[d]), 64'd0);
    chk("rdata_idle", rdata_o[d], 64'd0);
    valid_i[d] = 1'b1;
    addr_i[d]  = addr;
    wdata_i[d] = wd;
    we_i[d]    = we;
    rmem_i[d]  = 1'b0;
    @(posedge clk);
    if (we && !mis) begin
      model[d][idx] = wd;
      known[d][idx] = 1'b1;
    end
    #1 valid_i[d] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("ready_busy", 64'(ready_o[d]), 64'd0);
      chk("valid_lat", 64'(vmem_o[d]), 64'(k == lat));
    end
    if (chk_rd) chk("rdata", rdata_o[d], exp_rd);
`ifdef CPRV_DMEM_MISALIGN_ERR_EN
    chk("err", 64'(err_o[d]), 64'(mis));
`endif
    for (int b = 0; b < bp; b++) begin
      if (nxt_valid) begin
        valid_i[d] = 1'b1;
        addr_i[d]  = nxt_addr;
        we_i[d]    = 1'b0;
      end
      @(negedge clk);
      chk("bp_valid", 64'(vmem_o[d]), 64'd1);
      chk("bp_ready", 64'(ready_o[d]), 64'd0);
      if (chk_rd) chk("bp_rdata", rdata_o[d], exp_rd);
    end
    rmem_i[d] = 1'b1;
    @(posedge clk);
    #1 rmem_i[d] = 1'b0;
    if (!nxt_valid) valid_i[d] = 1'b0;
  endtask

  initial begin
    logic [63:0] a, w;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid_i[d] = 1'b0;
      we_i[d]    = 1'b0;
      rmem_i[d]  = 1'b0;
      addr_i[d]  = 64'd0;
      wdata_i[d] = 64'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 64'(vmem_o[d]), 64'd0);
      chk("rst_rdata", rdata_o[d], 64'd0);
    end
    rst_n = 1'b1;

    // Write then read at LATENCY=1 and LATENCY=4.
    txn(0, 64'h10, 64'hDEADBEEF_01234567, 1'b1, 0, 1'b0, 64'd0);
    txn(0, 64'h10, 64'd0, 1'b0, 0, 1'b0, 64'd0);
    txn(1, 64'h10, 64'hCAFEF00D_89ABCDEF, 1'b1, 0, 1'b0, 64'd0);
    txn(1, 64'h10, 64'd0, 1'b0, 0, 1'b0, 64'd0);

    // Backpressure with a pending read, accepted right after the handshake.
    txn(0, 64'h18, 64'h1111_2222_3333_4444, 1'b1, 0, 1'b0, 64'd0);
    txn(0, 64'h10, 64'd0, 1'b0, 5, 1'b1, 64'h18);
    txn(0, 64'h18, 64'd0, 1'b0, 0, 1'b0, 64'd0);
    txn(1, 64'h10, 64'd0, 1'b0, 5, 1'b1, 64'h10);
    txn(1, 64'h10, 64'd0, 1'b0, 0, 1'b0, 64'd0);

    // Wrap-around: 0x2000 maps to word 0.
    txn(0, 64'h2000, 64'h55, 1'b1, 0, 1'b0, 64'd0);
    txn(0, 64'h0, 64'd0, 1'b0, 0, 1'b0, 64'd0);

    // Reset during WAIT: response discarded, write kept.
    @(negedge clk);
    valid_i[1] = 1'b1;
    addr_i[1]  = 64'h40;
    wdata_i[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    we_i[1]    = 1'b1;
    @(posedge clk);
    model[1][8] = 64'hA5A5_5A5A_0F0F_F0F0;
    known[1][8] = 1'b1;
    #1 valid_i[1] = 1'b0;
    @(negedge clk);
    chk("wait_ready", 64'(ready_o[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rstmid_valid", 64'(vmem_o[1]), 64'd0);
    @(negedge clk);
    chk("rstmid_valid2", 64'(vmem_o[1]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrel_ready", 64'(ready_o[1]), 64'd1);
    chk("rstrel_valid", 64'(vmem_o[1]), 64'd0);
    txn(1, 64'h40, 64'd0, 1'b0, 0, 1'b0, 64'd0);

`ifdef CPRV_DMEM_MISALIGN_ERR_EN
    // Misaligned write is rejected and leaves the word untouched.
    txn(0, 64'h10, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1'b0, 64'd0);
    txn(0, 64'h13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0, 64'd0);
    txn(0, 64'h10, 64'd0, 1'b0, 0, 1'b0, 64'd0);
`endif

    // Random traffic over a few words with random upper and offset bits.
    for (int i = 0; i < 30; i++) begin
      for (int d = 0; d < 2; d++) begin
        a = (64'($urandom_range(0, 7)) << 3) | (64'($urandom_range(0, 3)) << 13)
            | 64'($urandom_range(0, 7));
        w = {$urandom, $urandom};
        txn(d, a, w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 64'd0);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
